// File: rtl/uart_alu_pkg.sv
// Shared types for the UART command engine.
// Opcodes, FSM states and header size.
package uart_alu_pkg;

  localparam int HDR_BYTES = 4;

  typedef enum logic [7:0] {
    OPC_ECHO = 8'hEC,
    OPC_ADD  = 8'hA8,
    OPC_MUL  = 8'h8C
  } opcode_e;

  typedef enum logic [3:0] {
    S_OPC,
    S_RSV,
    S_LLO,
    S_LHI,
    S_ECHO,
    S_ACC,
    S_MUL,
    S_RES,
    S_TAIL,
    S_DRAIN
  } state_e;

endpackage

// File: rtl/uart_alu_cmd_engine_mul.sv
// Shift-add multiplier, low half of the product.
// done_o is high WIDTH cycles after start_i; p_o is valid with it.
module alu_seq_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] p_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] p;
  logic [CW-1:0]    cnt;
  logic             busy;

  // the final partial product is folded in combinationally
  assign p_o    = p + (b[0] ? a : '0);
  assign done_o = busy & (cnt == CW'(1));

  // one multiplier bit per cycle
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      a    <= '0;
      b    <= '0;
      p    <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start_i) begin
      a    <= a_i;
      b    <= b_i;
      p    <= '0;
      cnt  <= CW'(WIDTH);
      busy <= 1'b1;
    end else if (busy) begin
      p   <= p_o;
      a   <= a << 1;
      b   <= b >> 1;
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_alu_cmd_engine.sv
// Framed byte-stream ECHO/ADD/MUL engine.
// Define UART_ALU_CKSUM_EN to append an XOR checksum byte.
module uart_alu_cmd_engine
  import uart_alu_pkg::*;
#(
  parameter int OPERAND_WIDTH = 32,
  parameter int LEN_WIDTH     = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] s_axis_tdata_i,
  input  logic       s_axis_tvalid_i,
  output logic       s_axis_tready_o,
  output logic [7:0] m_axis_tdata_o,
  output logic       m_axis_tvalid_o,
  input  logic       m_axis_tready_i,
  output logic       busy_o,
  output logic       err_o
);

  localparam int W  = OPERAND_WIDTH;
  localparam int N  = W / 8;
  localparam int BW = $clog2(N + 1);
  localparam logic [LEN_WIDTH-1:0] HDR = LEN_WIDTH'(HDR_BYTES);

`ifdef UART_ALU_CKSUM_EN
  localparam state_e DONE_ST = S_TAIL;
`else
  localparam state_e DONE_ST = S_OPC;
`endif

  state_e               state;
  logic [7:0]           opc;
  logic [7:0]           len_lo;
  logic [LEN_WIDTH-1:0] rem;
  logic [BW-1:0]        bcnt;
  logic                 first;
  logic [W-1:0]         word;
  logic [W-1:0]         acc;
  logic [7:0]           cksum;

  logic                 rdy;
  logic                 in_hs;
  logic                 out_hs;
  logic                 can_load;
  logic                 last;
  logic                 word_done;
  logic [W-1:0]         word_n;
  logic [LEN_WIDTH-1:0] len_full;
  logic [LEN_WIDTH-1:0] pay;
  logic                 len_short;
  logic                 len_ok;
  logic                 mul_start;
  logic                 mul_done;
  logic [W-1:0]         mul_p;

  assign in_hs     = s_axis_tvalid_i & s_axis_tready_o;
  assign out_hs    = m_axis_tvalid_o & m_axis_tready_i;
  assign can_load  = ~m_axis_tvalid_o | m_axis_tready_i;
  assign last      = (rem == LEN_WIDTH'(1));
  assign word_done = (bcnt == BW'(N - 1));
  assign word_n    = (word >> 8) | (W'(s_axis_tdata_i) << (W - 8));
  assign len_full  = LEN_WIDTH'({s_axis_tdata_i, len_lo});
  assign pay       = len_full - HDR;
  assign len_short = (len_full <= HDR);
  assign len_ok    = ((pay % LEN_WIDTH'(N)) == '0);
  assign busy_o    = (state != S_OPC);

  assign mul_start = (state == S_ACC) & in_hs & word_done
                   & ~first & (opc == OPC_MUL);

  alu_seq_mul #(.WIDTH(W)) u_mul (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (mul_start),
    .a_i     (acc),
    .b_i     (word_n),
    .done_o  (mul_done),
    .p_o     (mul_p)
  );

  // input ready per state; an idle engine waits for the reply to drain
  always_comb begin
    rdy = 1'b0;
    unique case (state)
      S_OPC:   rdy = ~m_axis_tvalid_o;
      S_RSV,
      S_LLO,
      S_LHI,
      S_ACC,
      S_DRAIN: rdy = 1'b1;
      S_ECHO:  rdy = can_load;
      default: rdy = 1'b0;
    endcase
    s_axis_tready_o = rdy & rst_ni;
  end

  // packet FSM with registered reply stream and error pulse
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state           <= S_OPC;
      opc             <= '0;
      len_lo          <= '0;
      rem             <= '0;
      bcnt            <= '0;
      first           <= 1'b0;
      word            <= '0;
      acc             <= '0;
      cksum           <= '0;
      m_axis_tvalid_o <= 1'b0;
      m_axis_tdata_o  <= '0;
      err_o           <= 1'b0;
    end else begin
      err_o <= 1'b0;
      if (out_hs) m_axis_tvalid_o <= 1'b0;
      unique case (state)
        S_OPC: begin
          cksum <= '0;
          if (in_hs) begin
            opc   <= s_axis_tdata_i;
            state <= S_RSV;
          end
        end
        S_RSV: if (in_hs) state <= S_LLO;
        S_LLO: begin
          if (in_hs) begin
            len_lo <= s_axis_tdata_i;
            state  <= S_LHI;
          end
        end
        S_LHI: begin
          if (in_hs) begin
            rem   <= pay;
            bcnt  <= '0;
            first <= 1'b1;
            if (len_short) begin
              state <= S_OPC;
            end else begin
              unique case (1'b1)
                (opc == OPC_ECHO): state <= S_ECHO;
                (opc == OPC_ADD),
                (opc == OPC_MUL): begin
                  state <= len_ok ? S_ACC : S_DRAIN;
                  err_o <= ~len_ok;
                end
                default: begin
                  state <= S_DRAIN;
                  err_o <= 1'b1;
                end
              endcase
            end
          end
        end
        S_ECHO: begin
          if (in_hs) begin
            m_axis_tdata_o  <= s_axis_tdata_i;
            m_axis_tvalid_o <= 1'b1;
            cksum           <= cksum ^ s_axis_tdata_i;
            rem             <= rem - 1'b1;
            if (last) state <= DONE_ST;
          end
        end
        S_ACC: begin
          if (in_hs) begin
            rem  <= rem - 1'b1;
            word <= word_n;
            bcnt <= bcnt + 1'b1;
            if (word_done) begin
              bcnt <= '0;
              if (first) begin
                first <= 1'b0;
                acc   <= word_n;
              end else if (opc == OPC_ADD) begin
                acc <= acc + word_n;
              end
              if (mul_start) state <= S_MUL;
              else if (last) state <= S_RES;
            end
          end
        end
        S_MUL: begin
          if (mul_done) begin
            acc   <= mul_p;
            state <= (rem == '0) ? S_RES : S_ACC;
          end
        end
        S_RES: begin
          if (can_load) begin
            m_axis_tdata_o  <= acc[7:0];
            m_axis_tvalid_o <= 1'b1;
            cksum           <= cksum ^ acc[7:0];
            acc             <= acc >> 8;
            bcnt            <= bcnt + 1'b1;
            if (word_done) begin
              bcnt  <= '0;
              state <= DONE_ST;
            end
          end
        end
        S_TAIL: begin
          if (can_load) begin
            m_axis_tdata_o  <= cksum;
            m_axis_tvalid_o <= 1'b1;
            state           <= S_OPC;
          end
        end
        S_DRAIN: begin
          if (in_hs) begin
            rem <= rem - 1'b1;
            if (last) state <= S_OPC;
          end
        end
        default: state <= S_OPC;
      endcase
    end
  end

endmodule
